// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops length-prefixed frames from an FWFT byte FIFO and streams the payload.
// Statistics counters are built only when FIFO_FRAME_READER_STATS_EN is defined; otherwise tied to 0.
module fifo_frame_reader #(
    parameter int P_MAX_LEN   = 1518,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [7:0]             fifo_data_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_rd_o,
    output logic [7:0]             m_data_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic [P_CNT_WIDTH-1:0] frames_o,
    output logic [P_CNT_WIDTH-1:0] drops_o
);
    // state   | meaning
    // HDR_HI  | waiting for length MSB
    // HDR_LO  | waiting for length LSB, classify frame
    // PAYLOAD | forwarding payload bytes to the output register
    // DROP    | discarding payload of an oversize frame
    typedef enum logic [1:0] {HDR_HI, HDR_LO, PAYLOAD, DROP} state_t;

    localparam logic [15:0] MAX_LEN = 16'(P_MAX_LEN);

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] remaining, remaining_nxt;
    logic [15:0] len;
    logic        pop;
    logic        frame_done;
    logic        frame_drop;

    assign len = {len_hi, fifo_data_i};
    // Only payload pops need room in the output register; header/drop pops never stall.
    assign pop       = ~fifo_empty_i & ((state != PAYLOAD) | ~m_valid_o | m_ready_i);
    assign fifo_rd_o = pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= HDR_HI;
            remaining <= 16'd0;
            len_hi    <= 8'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            if (pop && state == HDR_HI) begin
                len_hi <= fifo_data_i;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        frame_done    = 1'b0;
        frame_drop    = 1'b0;
        if (pop) begin
            case (state)
                HDR_HI: state_nxt = HDR_LO;
                HDR_LO: begin
                    remaining_nxt = len;
                    if (len == 16'd0) begin
                        state_nxt  = HDR_HI;
                        frame_drop = 1'b1;
                    end else if (len > MAX_LEN) begin
                        state_nxt  = DROP;
                        frame_drop = 1'b1;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining_nxt = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_nxt  = HDR_HI;
                        frame_done = 1'b1;
                    end
                end
                DROP: begin
                    remaining_nxt = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_nxt = HDR_HI;
                    end
                end
                default: state_nxt = HDR_HI;
            endcase
        end
    end

    // A payload pop in the same cycle as an accept replaces the byte and keeps valid high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_data_o  <= 8'd0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (pop && state == PAYLOAD) begin
            m_data_o  <= fifo_data_i;
            m_valid_o <= 1'b1;
            m_last_o  <= (remaining == 16'd1);
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

`ifdef FIFO_FRAME_READER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frames_o <= '0;
            drops_o  <= '0;
        end else begin
            if (frame_done && frames_o != '1) begin
                frames_o <= frames_o + 1'b1;
            end
            if (frame_drop && drops_o != '1) begin
                drops_o <= drops_o + 1'b1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = frame_done ^ frame_drop;
    assign frames_o     = '0;
    assign drops_o      = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: FIFO + frame-level scoreboard model, directed cases then randomized traffic.
module tb_fifo_frame_reader;
    localparam int MAXL = 12;
    localparam int CW   = 16;

    localparam int T_HDR     = 0;
    localparam int T_HDRDROP = 1;
    localparam int T_PAY     = 2;
    localparam int T_LAST    = 3;
    localparam int T_DROP    = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [7:0]    fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic [7:0]    m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic [CW-1:0] frames_o;
    logic [CW-1:0] drops_o;

    fifo_frame_reader #(.P_MAX_LEN(MAXL), .P_CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .frames_o(frames_o), .drops_o(drops_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // FIFO contents with a per-byte role tag assigned when the frame is pushed
    logic [7:0] fq[$];
    int         tq[$];
    logic [8:0] exp_stream[$];

    // expected output register and statistics
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_last;
    int         e_frames;
    int         e_drops;

    int gap_pct   = 0;
    int ready_pct = 100;
    bit pat_mode  = 0;
    int pcnt      = 0;

    logic [7:0] acc_d[$];
    logic       acc_l[$];
    int         acc_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef FIFO_FRAME_READER_STATS_EN
        int m;
        m = (1 << CW) - 1;
        return (v > m) ? CW'(m) : CW'(v);
`else
        return (v >= 0) ? '0 : '0;
`endif
    endfunction

    task automatic push_frame(input int len, input logic [7:0] base, input logic [7:0] stp);
        logic [15:0] l16;
        logic [7:0]  b;
        bit          bad;
        l16 = 16'(len);
        bad = (len == 0) || (len > MAXL);
        fq.push_back(l16[15:8]); tq.push_back(T_HDR);
        fq.push_back(l16[7:0]);  tq.push_back(bad ? T_HDRDROP : T_HDR);
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i) * stp;
            fq.push_back(b);
            if (bad) tq.push_back(T_DROP);
            else begin
                tq.push_back((i == len - 1) ? T_LAST : T_PAY);
                exp_stream.push_back({(i == len - 1), b});
            end
        end
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step();
        int   tag;
        logic pop_exp;
        logic accept;
        fifo_empty_i = (fq.size() == 0) || ($urandom_range(99) < gap_pct);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : 8'h00;
        if (pat_mode) m_ready_i = (pcnt % 3 == 0);
        else          m_ready_i = ($urandom_range(99) < ready_pct);
        pcnt++;
        #1;
        tag     = (fq.size() != 0) ? tq[0] : T_HDR;
        pop_exp = !fifo_empty_i && (!(tag == T_PAY || tag == T_LAST) || !e_valid || m_ready_i);
        chk("fifo_rd", fifo_rd_o, pop_exp);
        accept = e_valid && m_ready_i;
        if (accept) begin
            acc_d.push_back(m_data_o);
            acc_l.push_back(m_last_o);
            acc_c.push_back(cyc);
            if (exp_stream.size() == 0) chk("unexpected_byte", {m_last_o, m_data_o}, 32'h1ff);
            else chk("stream", {m_last_o, m_data_o}, exp_stream.pop_front());
            e_valid = 1'b0;
        end
        if (pop_exp) begin
            void'(fq.pop_front());
            void'(tq.pop_front());
            if (tag == T_PAY || tag == T_LAST) begin
                e_data  = fifo_data_i;
                e_valid = 1'b1;
                e_last  = (tag == T_LAST);
            end
            if (tag == T_LAST)    e_frames++;
            if (tag == T_HDRDROP) e_drops++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        chk("m_valid", m_valid_o, e_valid);
        if (e_valid) begin
            chk("m_data", m_data_o, e_data);
            chk("m_last", m_last_o, e_last);
        end
        chk("frames", frames_o, exp_cnt(e_frames));
        chk("drops", drops_o, exp_cnt(e_drops));
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((fq.size() != 0 || e_valid) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < maxc), 1);
    endtask

    task automatic clear_log();
        acc_d.delete();
        acc_l.delete();
        acc_c.delete();
    endtask

    task automatic chk_acc(input int idx, input logic [7:0] d, input logic l);
        if (idx < acc_d.size()) chk("acc_byte", {acc_l[idx], acc_d[idx]}, {l, d});
        else chk("acc_missing", acc_d.size(), idx + 1);
    endtask

    initial begin
        int f0, d0, len, r;
        rst_ni       = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 8'h00;
        m_ready_i    = 1'b0;
        e_data = 8'h00; e_valid = 1'b0; e_last = 1'b0; e_frames = 0; e_drops = 0;
        #3;
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_last", m_last_o, 0);
        chk("rst_frames", frames_o, 0);
        chk("rst_drops", drops_o, 0);
        chk("rst_rd", fifo_rd_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // single 3-byte frame
        clear_log(); f0 = e_frames;
        push_frame(3, 8'hA1, 8'h11);
        drain(50);
        chk("t1_count", acc_d.size(), 3);
        chk_acc(0, 8'hA1, 0); chk_acc(1, 8'hB2, 0); chk_acc(2, 8'hC3, 1);
        if (acc_c.size() == 3) begin
            chk("t1_gap01", acc_c[1] - acc_c[0], 1);
            chk("t1_gap12", acc_c[2] - acc_c[1], 1);
        end
        chk("t1_model_frames", e_frames - f0, 1);

        // back-to-back frames: two header cycles between 11 and 22
        clear_log();
        push_frame(1, 8'h11, 8'h00);
        push_frame(2, 8'h22, 8'h11);
        drain(50);
        chk("t2_count", acc_d.size(), 3);
        chk_acc(0, 8'h11, 1); chk_acc(1, 8'h22, 0); chk_acc(2, 8'h33, 1);
        if (acc_c.size() == 3) chk("t2_hdr_gap", acc_c[1] - acc_c[0], 3);

        // zero-length frame then 1-byte frame
        clear_log(); f0 = e_frames; d0 = e_drops;
        push_frame(0, 8'h00, 8'h00);
        push_frame(1, 8'h5A, 8'h00);
        drain(50);
        chk("t3_count", acc_d.size(), 1);
        chk_acc(0, 8'h5A, 1);
        chk("t3_model_drops", e_drops - d0, 1);
        chk("t3_model_frames", e_frames - f0, 1);

        // oversize frame drained silently
        clear_log(); d0 = e_drops;
        push_frame(MAXL + 1, 8'h40, 8'h01);
        push_frame(1, 8'h77, 8'h00);
        drain(80);
        chk("t4_count", acc_d.size(), 1);
        chk_acc(0, 8'h77, 1);
        chk("t4_model_drops", e_drops - d0, 1);

        // backpressure 1,0,0,... pattern
        clear_log(); pat_mode = 1; pcnt = 0;
        push_frame(4, 8'h01, 8'h01);
        drain(80);
        pat_mode = 0;
        chk("t5_count", acc_d.size(), 4);
        chk_acc(0, 8'h01, 0); chk_acc(1, 8'h02, 0); chk_acc(2, 8'h03, 0); chk_acc(3, 8'h04, 1);

        // reset mid-frame
        clear_log();
        push_frame(10, 8'h80, 8'h03);
        for (int i = 0; i < 4; i++) step();
        chk("t6_pre_valid", m_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        fq.delete(); tq.delete(); exp_stream.delete();
        fifo_empty_i = 1'b1;
        e_data = 8'h00; e_valid = 1'b0; e_last = 1'b0; e_frames = 0; e_drops = 0;
        #1;
        chk("t6_rst_valid", m_valid_o, 0);
        chk("t6_rst_data", m_data_o, 0);
        chk("t6_rst_last", m_last_o, 0);
        chk("t6_rst_frames", frames_o, 0);
        chk("t6_rst_drops", drops_o, 0);
        chk("t6_rst_rd", fifo_rd_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_log();
        push_frame(1, 8'h99, 8'h00);
        drain(50);
        chk("t6_count", acc_d.size(), 1);
        chk_acc(0, 8'h99, 1);

        // randomized traffic with FIFO gaps and backpressure
        gap_pct = 25; ready_pct = 70;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(9);
            if (r == 0)      len = 0;
            else if (r == 1) len = MAXL + $urandom_range(1, 4);
            else if (r == 2) len = MAXL;
            else if (r == 3) len = 1;
            else             len = $urandom_range(1, MAXL);
            push_frame(len, 8'($urandom_range(255)), 8'($urandom_range(255)));
        end
        drain(20000);
        chk("rand_stream_left", exp_stream.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
